video_path_aligner: RTL

Parametrised output stage for the VGA display path. It takes NCH processing paths, each with its own fixed pipeline latency, and delays each one so all paths line up with a common output latency. It delays hsync, vsync and the active-area flag by the same amount. It gates each path with that path's ready flag, and selects one path for display. A mode change is committed only at the start of an output vertical sync, so a mode switch never tears a frame. The block sits between the RGB/gray/Gaussian/Sobel/Canny generators and the VGA pins, in the 25 MHz VGA clock domain.

---
 rtl/video_path_if.sv | 36 +++
 rtl/video_path_aligner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/video_path_if.sv
// Bundle of raster, per-path pixel and mode-control signals between the
// processing generators and the VGA output stage.
interface video_path_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NCH  = 5,
    parameter int unsigned SELW = 3
);
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  active_in;
    logic [NCH*3*DW-1:0]   ch_data;
    logic [NCH-1:0]        ch_ready;
    logic [SELW-1:0]       mode_req;

    logic [DW-1:0]         pix_r;
    logic [DW-1:0]         pix_g;
    logic [DW-1:0]         pix_b;
    logic                  hsync_out;
    logic                  vsync_out;
    logic                  active_out;
    logic [SELW-1:0]       mode_cur;
    logic                  mode_pending;
    logic [15:0]           frame_cnt;

    modport master (
        output hsync_in, vsync_in, active_in, ch_data, ch_ready, mode_req,
        input  pix_r, pix_g, pix_b, hsync_out, vsync_out, active_out,
               mode_cur, mode_pending, frame_cnt
    );

    modport slave (
        input  hsync_in, vsync_in, active_in, ch_data, ch_ready, mode_req,
        output pix_r, pix_g, pix_b, hsync_out, vsync_out, active_out,
               mode_cur, mode_pending, frame_cnt
    );
endinterface

// File: rtl/video_path_aligner.sv
// Aligns NCH pipelines of differing latency to a common output latency,
// gates by per-path ready, selects one path, and switches mode only at vsync.
module video_path_aligner #(
    parameter int unsigned          DW        = 8,
    parameter int unsigned          NCH       = 5,
    parameter int unsigned          SELW      = 3,
    parameter int unsigned          LW        = 4,
    parameter logic [NCH*LW-1:0]    LAT_VEC   = 20'h64200,
    parameter int unsigned          OUT_LAT   = 7,
    parameter logic [SELW-1:0]      INIT_MODE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    video_path_if.slave  vif
);
    localparam int unsigned PW = 3 * DW;

    logic [OUT_LAT-1:0] hs_q;
    logic [OUT_LAT-1:0] vs_q;
    logic [OUT_LAT-1:0] act_q;

    // Sync/active delay lines; syncs idle high so the monitor sees no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= '1;
            vs_q  <= '1;
            act_q <= '0;
        end else begin
            hs_q[0]  <= vif.hsync_in;
            vs_q[0]  <= vif.vsync_in;
            act_q[0] <= vif.active_in;
            for (int unsigned k = 1; k < OUT_LAT; k++) begin
                hs_q[k]  <= hs_q[k-1];
                vs_q[k]  <= vs_q[k-1];
                act_q[k] <= act_q[k-1];
            end
        end
    end

    logic hsync_out;
    logic vsync_out;
    logic active_out;

    assign hsync_out  = hs_q[OUT_LAT-1];
    assign vsync_out  = vs_q[OUT_LAT-1];
    assign active_out = act_q[OUT_LAT-1];

    logic [NCH*PW-1:0] data_tap;
    logic [NCH-1:0]    rdy_tap;

    for (genvar i = 0; i < NCH; i++) begin : g_path
        localparam int unsigned LAT = 32'(LAT_VEC[i*LW +: LW]);
        localparam int unsigned D   = OUT_LAT - LAT;

        logic [PW-1:0] d_q [D];
        logic [D-1:0]  r_q;

        // Path delay line; cleared during input vsync so stale frames never leak.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k < D; k++) d_q[k] <= '0;
                r_q <= '0;
            end else if (!vif.vsync_in) begin
                for (int unsigned k = 0; k < D; k++) d_q[k] <= '0;
                r_q <= '0;
            end else begin
                d_q[0] <= vif.ch_data[i*PW +: PW];
                r_q[0] <= vif.ch_ready[i];
                for (int unsigned k = 1; k < D; k++) begin
                    d_q[k] <= d_q[k-1];
                    r_q[k] <= r_q[k-1];
                end
            end
        end

        assign data_tap[i*PW +: PW] = d_q[D-1];
        assign rdy_tap[i]           = r_q[D-1];
    end

    logic [SELW-1:0] req_q,      req_d;
    logic [SELW-1:0] mode_cur_q, mode_cur_d;
    logic [15:0]     cnt_q,      cnt_d;
    logic            vs_prev_q;
    logic            commit;
    logic            req_valid;

    assign commit    = vs_prev_q & ~vsync_out;
    assign req_valid = 32'(vif.mode_req) < NCH;

    always_comb begin
        req_d      = req_q;
        mode_cur_d = mode_cur_q;
        cnt_d      = cnt_q;
        if (req_valid) req_d = vif.mode_req;
        if (commit) begin
            mode_cur_d = req_q;
            cnt_d      = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= INIT_MODE;
            mode_cur_q <= INIT_MODE;
            cnt_q      <= '0;
            vs_prev_q  <= 1'b1;
        end else begin
            req_q      <= req_d;
            mode_cur_q <= mode_cur_d;
            cnt_q      <= cnt_d;
            vs_prev_q  <= vsync_out;
        end
    end

    logic [PW-1:0] sel_data;
    logic          sel_rdy;
    logic [PW-1:0] pix;

    // Output mux straight off the registered taps.
    always_comb begin
        sel_data = '0;
        sel_rdy  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (mode_cur_q == SELW'(i)) begin
                sel_data = data_tap[i*PW +: PW];
                sel_rdy  = rdy_tap[i];
            end
        end
        pix = (active_out && sel_rdy) ? sel_data : '0;
    end

    assign vif.pix_r        = pix[3*DW-1 -: DW];
    assign vif.pix_g        = pix[2*DW-1 -: DW];
    assign vif.pix_b        = pix[DW-1:0];
    assign vif.hsync_out    = hsync_out;
    assign vif.vsync_out    = vsync_out;
    assign vif.active_out   = active_out;
    assign vif.mode_cur     = mode_cur_q;
    assign vif.mode_pending = (req_q != mode_cur_q);
    assign vif.frame_cnt    = cnt_q;
endmodule
